// File: rtl/uart_tx_arbiter_if.sv
// Client/UART-side bundle of uart_tx_arbiter. The master modport is the arbiter;
// the slave modport is the combined client and TX FIFO side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_tx_start;
  logic [7:0]           uart_tx_data_in;
  logic                 uart_tx_fifo_full;
  logic                 grant_valid;
  logic [IDW-1:0]       grant_id;
  logic                 timeout_pulse;

  modport master (
    input  req_valid, req_data, req_last, uart_tx_fifo_full,
    output req_ready, uart_tx_start, uart_tx_data_in, grant_valid, grant_id, timeout_pulse
  );

  modport slave (
    output req_valid, req_data, req_last, uart_tx_fifo_full,
    input  req_ready, uart_tx_start, uart_tx_data_in, grant_valid, grant_id, timeout_pulse
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter into one UART TX FIFO; 1-cycle grant, then 1 byte/cycle
// while FIFO not full (full stalls, never times out). UART_ARB_TAG_EN prefixes each packet with '0'+id.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.master bus
);
  localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TAG    = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [CNTW-1:0] idle_q, idle_d;
  logic            pulse_q, pulse_d;

  logic [IDW-1:0]  win;
  logic            found;
  int              idx;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;

  // Search starts one past the previous owner so every client gets a turn.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDW'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    grant_d             = grant_q;
    last_d              = last_q;
    idle_d              = idle_q;
    pulse_d             = 1'b0;
    bus.req_ready       = '0;
    bus.uart_tx_start   = 1'b0;
    bus.uart_tx_data_in = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = win;
          idle_d  = '0;
`ifdef UART_ARB_TAG_EN
          state_d = ST_TAG;
`else
          state_d = ST_STREAM;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG: begin
        if (!bus.uart_tx_fifo_full) begin
          bus.uart_tx_start   = 1'b1;
          bus.uart_tx_data_in = 8'h30 + {{(8-IDW){1'b0}}, grant_q};
          state_d             = ST_STREAM;
        end
      end
`endif
      ST_STREAM: begin
        if (sel_valid) begin
          // A valid byte held off by a full FIFO leaves idle_q untouched.
          if (!bus.uart_tx_fifo_full) begin
            bus.req_ready       = NUM_REQ'(1) << grant_q;
            bus.uart_tx_start   = 1'b1;
            bus.uart_tx_data_in = sel_data;
            idle_d              = '0;
            if (sel_last) begin
              last_d  = grant_q;
              state_d = ST_IDLE;
            end
          end
        end else if (idle_q == CNTW'(TIMEOUT - 1)) begin
          pulse_d = 1'b1;
          last_d  = grant_q;
          state_d = ST_IDLE;
        end else begin
          idle_d = idle_q + CNTW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      idle_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      idle_q  <= idle_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.grant_valid   = (state_q != ST_IDLE);
  assign bus.grant_id      = grant_q;
  assign bus.timeout_pulse = pulse_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and random stimulus for uart_tx_arbiter, checked every cycle against a
// packet-level model of owner, round-robin pointer and idle count.
module tb_uart_tx_arbiter;
  localparam int NUM = 4;
  localparam int TMO = 8;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [7:0] gap;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM)) bus ();
  uart_tx_arbiter #(.NUM_REQ(NUM), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  ent_t       cq[NUM][$];
  bit         pres[NUM];
  bit         armed[NUM];
  int         gapc[NUM];
  logic       rst_v = 1'b0;
  logic       full_v = 1'b0;
  logic [7:0] wlog[$];
  logic [7:0] eq[$];
  int         npulse = 0;

  int m_own = -1, m_gid = 0, m_last = NUM - 1, m_idle = 0;
  bit m_pulse = 0, m_tag = 0, m_on = 0;

  logic [NUM-1:0] o_ready;
  logic           o_start, o_gv, o_pulse;
  logic [7:0]     o_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit busy();
    busy = (m_own >= 0);
    for (int i = 0; i < NUM; i++) if (cq[i].size() != 0) busy = 1'b1;
  endfunction

  task automatic tick();
    logic [NUM-1:0] e_ready;
    logic           e_start;
    logic [7:0]     e_data;
    int             acc;
    bit             fnd;
    @(negedge clk);
    rst_n = rst_v;
    bus.uart_tx_fifo_full = full_v;
    for (int i = 0; i < NUM; i++) begin
      bus.req_valid[i]      = pres[i];
      bus.req_data[8*i +: 8] = pres[i] ? cq[i][0].d : 8'h00;
      bus.req_last[i]       = pres[i] ? cq[i][0].l : 1'b0;
    end
    #1;
    e_ready = '0; e_start = 1'b0; e_data = 8'h00; acc = -1;
    if (m_own >= 0) begin
      if (m_tag) begin
        if (!full_v) begin e_start = 1'b1; e_data = 8'(8'h30 + m_own); end
      end else if (pres[m_own] && !full_v) begin
        e_start = 1'b1; e_data = cq[m_own][0].d; e_ready[m_own] = 1'b1; acc = m_own;
      end
    end
    o_ready = bus.req_ready; o_start = bus.uart_tx_start; o_data = bus.uart_tx_data_in;
    o_gv = bus.grant_valid; o_pulse = bus.timeout_pulse;
    if (m_on) begin
      chk("req_ready", o_ready, e_ready);
      chk("tx_start", o_start, e_start);
      chk("tx_data", o_data, e_data);
      chk("grant_valid", o_gv, (m_own >= 0));
      chk("grant_id", bus.grant_id, m_gid);
      chk("timeout_pulse", o_pulse, m_pulse);
      if (o_start === 1'b1) wlog.push_back(o_data);
      if (o_pulse === 1'b1) begin npulse++; chk("pulse_gv", o_gv, 1'b0); end
    end
    @(posedge clk);
    if (!rst_v) begin
      m_on = 1; m_own = -1; m_gid = 0; m_last = NUM - 1; m_idle = 0; m_pulse = 0; m_tag = 0;
    end else begin
      m_pulse = 0;
      if (m_own < 0) begin
        fnd = 0;
        for (int k = 1; k <= NUM; k++) begin
          if (!fnd && pres[(m_last + k) % NUM]) begin
            fnd = 1; m_own = (m_last + k) % NUM; m_gid = m_own; m_idle = 0; m_tag = TAG_EN;
          end
        end
      end else if (m_tag) begin
        if (!full_v) m_tag = 0;
      end else if (pres[m_own]) begin
        if (!full_v) begin
          m_idle = 0;
          if (cq[m_own][0].l) begin m_last = m_own; m_own = -1; end
        end
      end else if (m_idle == TMO - 1) begin
        m_pulse = 1; m_last = m_own; m_own = -1;
      end else begin
        m_idle++;
      end
    end
    if (acc >= 0) begin void'(cq[acc].pop_front()); pres[acc] = 0; end
    for (int i = 0; i < NUM; i++) begin
      if (!pres[i] && cq[i].size() != 0) begin
        if (!armed[i]) begin gapc[i] = int'(cq[i][0].gap); armed[i] = 1; end
        if (gapc[i] == 0) begin pres[i] = 1; armed[i] = 0; end
        else gapc[i]--;
      end
    end
  endtask

  task automatic push(input int c, input logic [7:0] base, input int len, input int gap_mid);
    for (int j = 0; j < len; j++)
      cq[c].push_back('{d: 8'(base + j), l: (j == len - 1), gap: (j == 0) ? 8'd0 : 8'(gap_mid)});
  endtask

  task automatic exp_pkt(input int c, input logic [7:0] base, input int len);
    if (TAG_EN) eq.push_back(8'(8'h30 + c));
    for (int j = 0; j < len; j++) eq.push_back(8'(base + j));
  endtask

  task automatic drain(input string tag);
    int lim = 3000;
    while (busy() && lim > 0) begin tick(); lim--; end
    repeat (2) tick();
    chk(tag, busy(), 1'b0);
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_len"}, wlog.size(), eq.size());
    for (int i = 0; i < eq.size() && i < wlog.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), wlog[i], eq[i]);
    wlog.delete(); eq.delete();
  endtask

  task automatic clear_clients();
    for (int i = 0; i < NUM; i++) begin cq[i].delete(); pres[i] = 0; armed[i] = 0; gapc[i] = 0; end
  endtask

  initial begin
    int p0;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.uart_tx_fifo_full = 1'b0;
    clear_clients();

    // Reset: everything quiet afterwards.
    rst_v = 1'b0;
    repeat (2) tick();
    chk("rst_ready", o_ready, '0);
    chk("rst_start", o_start, 1'b0);
    chk("rst_data", o_data, 8'h00);
    chk("rst_gv", o_gv, 1'b0);
    rst_v = 1'b1;
    tick();

    // Clients 1 and 2 together: whole packet of 1, then 2.
    push(1, 8'h11, 2, 0); push(2, 8'h21, 2, 0);
    exp_pkt(1, 8'h11, 2); exp_pkt(2, 8'h21, 2);
    drain("t1_drain"); cmp_log("t1");

    // Client 3 owns the FIFO; client 0 arrives mid-packet and waits, then wins via wrap.
    push(3, 8'h31, 3, 0);
    repeat (2) tick();
    push(0, 8'h01, 1, 0);
    exp_pkt(3, 8'h31, 3); exp_pkt(0, 8'h01, 1);
    drain("t2_drain"); cmp_log("t2");

    // 50 cycles of FIFO full mid-packet: stall without timeout.
    p0 = npulse;
    push(1, 8'h41, 4, 0);
    repeat (3) tick();
    full_v = 1'b1;
    repeat (50) tick();
    full_v = 1'b0;
    exp_pkt(1, 8'h41, 4);
    drain("t3_drain"); cmp_log("t3");
    chk("t3_no_timeout", npulse - p0, 0);

    // Client 2 stalls mid-packet past TIMEOUT; waiting client 3 takes over.
    p0 = npulse;
    push(2, 8'h51, 2, 20); push(3, 8'h61, 2, 0);
    exp_pkt(2, 8'h51, 1); exp_pkt(3, 8'h61, 2);
    if (TAG_EN) eq.push_back(8'h32);
    eq.push_back(8'h52);
    drain("t4_drain"); cmp_log("t4");
    chk("t4_one_timeout", npulse - p0, 1);

    // Reset mid-packet truncates it; client 0 wins first afterwards.
    push(1, 8'h71, 4, 0);
    repeat (3) tick();
    rst_v = 1'b0;
    clear_clients();
    tick();
    wlog.delete();
    rst_v = 1'b1;
    push(2, 8'h81, 1, 0); push(0, 8'h91, 1, 0);
    tick();
    chk("rst2_ready", o_ready, '0);
    chk("rst2_start", o_start, 1'b0);
    chk("rst2_data", o_data, 8'h00);
    chk("rst2_gv", o_gv, 1'b0);
    exp_pkt(0, 8'h91, 1); exp_pkt(2, 8'h81, 1);
    drain("t5_drain"); cmp_log("t5");

    // Single-byte 8'h41 from client 2 (tagged build prefixes 8'h32).
    push(2, 8'h41, 1, 0);
    exp_pkt(2, 8'h41, 1);
    drain("t6_drain"); cmp_log("t6");

    // Random traffic, gaps and backpressure against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        int c = $urandom_range(0, NUM - 1);
        int len = $urandom_range(1, 4);
        if (cq[c].size() < 8)
          for (int j = 0; j < len; j++)
            cq[c].push_back('{d: 8'($urandom), l: (j == len - 1),
                              gap: ($urandom_range(0, 9) == 0) ? 8'($urandom_range(6, 12))
                                                               : 8'($urandom_range(0, 1))});
      end
      full_v = ($urandom_range(0, 4) == 0);
      tick();
    end
    full_v = 1'b0;
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
